norm_shift_pipe: RTL and testbench

- Normalization stage directly downstream of the leading-one detector in the posit/float datapath.
- Takes an unnormalized mantissa and its exponent, finds the leading-one position, left-shifts the mantissa so bit N-1 is set, and subtracts the shift from the exponent.
- Two-stage registered pipeline with valid/ready handshake on both sides. It feeds rounding/packing logic.

---
 rtl/norm_pkg.sv | 22 ++
 rtl/norm_shift_pipe_if.sv | 41 ++++
 rtl/norm_lzc.sv | 35 +++
 rtl/norm_shift_pipe.sv | 101 ++++++++++
 tb/tb_norm_shift_pipe.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/norm_pkg.sv
// Shared helpers for the normalization stage: width function, default widths, zero-result constants.
// Optional feature macro used by this block: NORM_UFLOW_EN (adds out_uflow).
package norm_pkg;

    function automatic int norm_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int NORM_N  = 16;
    localparam int NORM_E  = 8;
    localparam int NORM_S  = norm_clog2(NORM_N);
    localparam int NORM_EW = NORM_E + 1;

    // An all-zero mantissa normalizes to a canonical zero: no shift, zero exponent.
    localparam int  ZERO_RESULT_SHIFT = 0;
    localparam int  ZERO_RESULT_EXP   = 0;
    localparam logic ZERO_RESULT_FLAG = 1'b1;

endpackage

// File: rtl/norm_shift_pipe_if.sv
// Handshake/data bundle for norm_shift_pipe; slave is the pipe, master is the driver/consumer.
// With NORM_UFLOW_EN defined the bundle also carries out_uflow.
interface norm_shift_pipe_if
    import norm_pkg::*;
#(
    parameter int N = NORM_N,
    parameter int E = NORM_E
);
    localparam int S = norm_clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_mant;
    logic [E-1:0] in_exp;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_mant;
    logic [E:0]   out_exp;
    logic [S-1:0] out_shift;
    logic         out_zero;
`ifdef NORM_UFLOW_EN
    logic         out_uflow;
`endif

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
`ifdef NORM_UFLOW_EN
        output out_uflow,
`endif
        output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero
    );

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
`ifdef NORM_UFLOW_EN
        input  out_uflow,
`endif
        input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero
    );

endinterface

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter built as a recursive halving tree.
// Non-power-of-two widths are zero-padded at the LSB end; cnt is meaningless when zero=1.
module norm_lzc
    import norm_pkg::*;
#(
    parameter int N = 16,
    localparam int S = norm_clog2(N)
) (
    input  logic [N-1:0] value,
    output logic [S-1:0] cnt,
    output logic         zero
);
    localparam int P = 1 << S;

    generate
        if (P != N) begin : g_pad
            logic [P-1:0] padded;
            assign padded = {value, {(P - N){1'b0}}};
            norm_lzc #(.N(P)) u_core (.value(padded), .cnt(cnt), .zero(zero));
        end else if (N == 2) begin : g_leaf
            assign cnt  = ~value[1];
            assign zero = ~|value;
        end else begin : g_split
            logic [S-2:0] hi_cnt;
            logic [S-2:0] lo_cnt;
            logic         hi_zero;
            logic         lo_zero;
            norm_lzc #(.N(N / 2)) u_hi (.value(value[N-1:N/2]), .cnt(hi_cnt), .zero(hi_zero));
            norm_lzc #(.N(N / 2)) u_lo (.value(value[N/2-1:0]), .cnt(lo_cnt), .zero(lo_zero));
            assign cnt  = {hi_zero, hi_zero ? lo_cnt : hi_cnt};
            assign zero = hi_zero & lo_zero;
        end
    endgenerate

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: stage 1 counts leading zeros, stage 2 shifts mantissa and adjusts exponent.
// Define NORM_UFLOW_EN to add out_uflow (result exponent does not fit in E bits).
module norm_shift_pipe
    import norm_pkg::*;
#(
    parameter int N = NORM_N,
    parameter int E = NORM_E
) (
    input  logic               clk,
    input  logic               rst,
    norm_shift_pipe_if.slave   bus
);
    localparam int S  = norm_clog2(N);
    localparam int EW = E + 1;

    logic         adv1;
    logic         adv2;
    logic [S-1:0] lzc_cnt;
    logic         lzc_zero;

    logic         s1_valid;
    logic [N-1:0] s1_mant;
    logic [E-1:0] s1_exp;
    logic [S-1:0] s1_lzc;
    logic         s1_zero;

    logic          s2_valid;
    logic [N-1:0]  s2_mant;
    logic [EW-1:0] s2_exp;
    logic [S-1:0]  s2_shift;
    logic          s2_zero;

    logic [N-1:0]  mant_sh;
    logic [EW-1:0] exp_res;

    norm_lzc #(.N(N)) u_lzc (.value(bus.in_mant), .cnt(lzc_cnt), .zero(lzc_zero));

    // No skid buffer: a stalled consumer back-pressures the producer in the same cycle.
    assign adv2         = !s2_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mant <= bus.in_mant;
                s1_exp  <= bus.in_exp;
                s1_lzc  <= lzc_zero ? S'(ZERO_RESULT_SHIFT) : lzc_cnt;
                s1_zero <= lzc_zero;
            end
        end
    end

    // Exponent is widened by one bit before subtracting, so it can never wrap.
    assign mant_sh = s1_mant << s1_lzc;
    assign exp_res = {s1_exp[E-1], s1_exp} - EW'(s1_lzc);

`ifdef NORM_UFLOW_EN
    logic s2_uflow;
    assign bus.out_uflow = s2_uflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_shift <= '0;
            s2_zero  <= 1'b0;
`ifdef NORM_UFLOW_EN
            s2_uflow <= 1'b0;
`endif
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mant  <= s1_zero ? '0 : mant_sh;
                s2_exp   <= s1_zero ? EW'(ZERO_RESULT_EXP) : exp_res;
                s2_shift <= s1_lzc;
                s2_zero  <= s1_zero ? ZERO_RESULT_FLAG : 1'b0;
`ifdef NORM_UFLOW_EN
                // Only the negative side can escape E bits: top two bits disagree.
                s2_uflow <= !s1_zero && (exp_res[E] ^ exp_res[E-1]);
`endif
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_mant  = s2_mant;
    assign bus.out_exp   = s2_exp;
    assign bus.out_shift = s2_shift;
    assign bus.out_zero  = s2_zero;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Directed self-checking bench for norm_shift_pipe (N=16, E=8); out_uflow checks need NORM_UFLOW_EN.
module tb_norm_shift_pipe;
    import norm_pkg::*;

    localparam int N  = 16;
    localparam int E  = 8;
    localparam int S  = NORM_S;
    localparam int EW = NORM_EW;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    norm_shift_pipe_if #(.N(N), .E(E)) bus ();
    norm_shift_pipe #(.N(N), .E(E)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [N-1:0]  V_MANT  [5] = '{16'h0001, 16'h8000, 16'h00F0, 16'h0003, 16'h7FFF};
    localparam logic [E-1:0]  V_EXP   [5] = '{8'd10, 8'd3, 8'd0, 8'h80, 8'd127};
    localparam logic [N-1:0]  X_MANT  [5] = '{16'h8000, 16'h8000, 16'hF000, 16'hC000, 16'hFFFE};
    localparam logic [S-1:0]  X_SHIFT [5] = '{4'd15, 4'd0, 4'd8, 4'd14, 4'd1};
    localparam logic [EW-1:0] X_EXP   [5] = '{9'h1FB, 9'h003, 9'h1F8, 9'h172, 9'h07E};

    localparam logic [N-1:0]  B_MANT  [4] = '{16'h0001, 16'h0030, 16'h4000, 16'h0F00};
    localparam logic [E-1:0]  B_EXP   [4] = '{8'd0, 8'd5, 8'hFD, 8'd20};
    localparam logic [N-1:0]  BX_MANT [4] = '{16'h8000, 16'hC000, 16'h8000, 16'hF000};
    localparam logic [EW-1:0] BX_EXP  [4] = '{9'h1F1, 9'h1FB, 9'h1FC, 9'h010};

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mant = 16'h1234;
        bus.in_exp = 8'd5;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_mant !== 16'h0) begin bad++; $display("FAIL reset_out_mant: got %h want 0", bus.out_mant); end
        total++; if (bus.out_exp !== 9'h0) begin bad++; $display("FAIL reset_out_exp: got %h want 0", bus.out_exp); end
        total++; if (bus.out_shift !== 4'h0) begin bad++; $display("FAIL reset_out_shift: got %h want 0", bus.out_shift); end
        total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero: got %b want 0", bus.out_zero); end
`ifdef NORM_UFLOW_EN
        total++; if (bus.out_uflow !== 1'b0) begin bad++; $display("FAIL reset_out_uflow: got %b want 0", bus.out_uflow); end
`endif
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignored_input: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_normalize();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_mant = V_MANT[i];
            bus.in_exp = V_EXP[i];
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL norm_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL norm_latency_early[%0d]: out_valid got %b want 0", i, bus.out_valid); end
            @(posedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL norm_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            total++; if (bus.out_mant !== X_MANT[i]) begin bad++; $display("FAIL norm_mant[%0d]: got %h want %h", i, bus.out_mant, X_MANT[i]); end
            total++; if (bus.out_shift !== X_SHIFT[i]) begin bad++; $display("FAIL norm_shift[%0d]: got %0d want %0d", i, bus.out_shift, X_SHIFT[i]); end
            total++; if (bus.out_exp !== X_EXP[i]) begin bad++; $display("FAIL norm_exp[%0d]: got %h want %h", i, bus.out_exp, X_EXP[i]); end
            total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL norm_zero[%0d]: got %b want 0", i, bus.out_zero); end
        end
    endtask

    task automatic test_zero();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mant = 16'h0000;
        bus.in_exp = 8'hF9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL zero_out_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.out_zero !== 1'b1) begin bad++; $display("FAIL zero_flag: got %b want 1", bus.out_zero); end
        total++; if (bus.out_mant !== 16'h0) begin bad++; $display("FAIL zero_mant: got %h want 0", bus.out_mant); end
        total++; if (bus.out_exp !== 9'h0) begin bad++; $display("FAIL zero_exp: got %h want 0", bus.out_exp); end
        total++; if (bus.out_shift !== 4'h0) begin bad++; $display("FAIL zero_shift: got %0d want 0", bus.out_shift); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        bit acc;
        bit emit;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (cyc >= 4);
            bus.in_valid = (sent < 4);
            bus.in_mant = B_MANT[sent < 4 ? sent : 3];
            bus.in_exp = B_EXP[sent < 4 ? sent : 3];
            #1;
            acc = bus.in_valid && bus.in_ready;
            emit = bus.out_valid && bus.out_ready;
            if (cyc == 2 || cyc == 3) begin
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready[%0d]: got %b want 0", cyc, bus.in_ready); end
                total++; if (sent != 2) begin bad++; $display("FAIL b2b_accepts[%0d]: got %0d want 2", cyc, sent); end
                total++; if (bus.out_valid !== 1'b1 || bus.out_mant !== BX_MANT[0] || bus.out_exp !== BX_EXP[0])
                    begin bad++; $display("FAIL b2b_stall_hold[%0d]: got v=%b %h/%h want v=1 %h/%h", cyc, bus.out_valid, bus.out_mant, bus.out_exp, BX_MANT[0], BX_EXP[0]); end
            end
            if (emit) begin
                total++;
                if (got >= 4) begin
                    bad++; $display("FAIL b2b_extra_output: got %h/%h want none", bus.out_mant, bus.out_exp);
                end else if (bus.out_mant !== BX_MANT[got] || bus.out_exp !== BX_EXP[got]) begin
                    bad++; $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", got, bus.out_mant, bus.out_exp, BX_MANT[got], BX_EXP[got]);
                end
                got++;
            end
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        total++; if (got != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
    endtask

    task automatic test_reset_flush();
        int spurious = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mant = 16'h0100;
        bus.in_exp = 8'd1;
        @(posedge clk);
        #1;
        bus.in_mant = 16'h0200;
        @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            begin bad++; $display("FAIL flush_filled: got v=%b rdy=%b want v=1 rdy=0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_rst_ready: got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_rst_ready_hold: got %b want 0", bus.in_ready); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_release_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL flush_discarded: got %0d outputs want 0", spurious); end
        bus.in_valid = 1'b1;
        bus.in_mant = 16'h0002;
        bus.in_exp = 8'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_mant !== 16'h8000 || bus.out_exp !== 9'h1F2 || bus.out_shift !== 4'd14)
            begin bad++; $display("FAIL flush_fresh: got v=%b %h/%h/%0d want v=1 8000/1f2/14", bus.out_valid, bus.out_mant, bus.out_exp, bus.out_shift); end
    endtask

`ifdef NORM_UFLOW_EN
    task automatic test_uflow();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mant = 16'h0001;
        bus.in_exp = 8'h80;
        @(posedge clk);
        #1;
        bus.in_exp = 8'h9C;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        total++; if (bus.out_exp !== 9'h171) begin bad++; $display("FAIL uflow_exp: got %h want 171", bus.out_exp); end
        total++; if (bus.out_uflow !== 1'b1) begin bad++; $display("FAIL uflow_set: got %b want 1", bus.out_uflow); end
        @(posedge clk);
        #1;
        total++; if (bus.out_exp !== 9'h18D) begin bad++; $display("FAIL uflow_exp2: got %h want 18d", bus.out_exp); end
        total++; if (bus.out_uflow !== 1'b0) begin bad++; $display("FAIL uflow_clear: got %b want 0", bus.out_uflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_normalize();
        test_zero();
        test_back_to_back();
        test_reset_flush();
`ifdef NORM_UFLOW_EN
        test_uflow();
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
